alu_cmd_ctrl: RTL and testbench
===============================

Name: alu_cmd_ctrl

Overview:
- Command front-end that sits directly upstream of the ALU.
- Parses byte frames from the UART receiver, loads the ALU operands and function, and pulses the ALU enable.
- Captures the registered 16-bit result and returns it to the UART transmitter as two bytes, LSB first.
- Owns the full command/response sequence between the serial link and the ALU.

Parameters:
- DATA_WIDTH, 8, width of RX/TX bytes and of each ALU operand.
- RES_WIDTH, 16, ALU result width; must equal 2*DATA_WIDTH.
- CMD_OP, 8'hCC, command byte for a full operation: operands plus function.
- CMD_OP_NOOPR, 8'hDD, command byte for an operation that reuses the stored operands and supplies only a function.
- WAIT_MAX, 4, maximum cycles spent in ALU_WAIT before timeout.

Ports:
- CLK  input  1  system clock.
- Reset  input  1  asynchronous active-low reset.
- RX_P_DATA  input  DATA_WIDTH  received byte.
- RX_D_VLD  input  1  single-cycle strobe; RX_P_DATA is valid this cycle.
- ALU_OUT  input  RES_WIDTH  registered ALU result.
- ALU_Out_valid  input  1  ALU result-valid flag.
- TX_busy  input  1  transmitter cannot accept a byte.
- ALU_A  output  DATA_WIDTH  operand A (registered).
- ALU_B  output  DATA_WIDTH  operand B (registered).
- ALU_FUN  output  4  ALU function code (registered).
- ALU_EN  output  1  ALU enable, one-cycle pulse.
- TX_P_DATA  output  DATA_WIDTH  byte offered to the transmitter.
- TX_D_VLD  output  1  TX_P_DATA is valid.
- Busy  output  1  high in every state except IDLE.
- Err  output  1  one-cycle pulse on ALU timeout.

Behaviour:
- Clocking and reset: one clock domain. Asynchronous active-low reset on Reset; all state is released synchronously to CLK.
- Reset values: state = IDLE; ALU_A, ALU_B, ALU_FUN, TX_P_DATA and the result register = 0; ALU_EN, TX_D_VLD, Busy, Err = 0.
- Reset asserted mid-operation aborts immediately to these values. A partially received frame is discarded.
- States: IDLE, GET_A, GET_B, GET_FUN, ALU_START, ALU_WAIT, SEND_LSB, SEND_MSB. State changes on CLK edges only.
- IDLE:
  - On RX_D_VLD with byte == CMD_OP, go to GET_A.
  - On RX_D_VLD with byte == CMD_OP_NOOPR, go to GET_FUN.
  - Any other byte is dropped and the state stays IDLE.
- GET_A: on RX_D_VLD, ALU_A <= byte, go to GET_B.
- GET_B: on RX_D_VLD, ALU_B <= byte, go to GET_FUN.
- GET_FUN: on RX_D_VLD, ALU_FUN <= byte[3:0] (upper nibble ignored), go to ALU_START. Codes 4'hF are passed through unchanged; the ALU returns 0 for them.
- No inter-byte timeout: a GET_x state waits indefinitely.
- ALU_START: lasts exactly one cycle with ALU_EN = 1, then go to ALU_WAIT. ALU_EN is 0 in every other state.
- ALU_WAIT:
  - A cycle counter is cleared on entry.
  - When ALU_Out_valid = 1, capture ALU_OUT into the result register and go to SEND_LSB. The nominal ALU path produces this in the first ALU_WAIT cycle.
  - If WAIT_MAX cycles elapse without valid, pulse Err for one cycle and go to IDLE; nothing is transmitted.
- SEND_LSB: TX_D_VLD = 1, TX_P_DATA = result[7:0]. A byte is accepted on a CLK edge where TX_D_VLD = 1 and TX_busy = 0; on acceptance go to SEND_MSB.
- SEND_MSB: TX_D_VLD = 1, TX_P_DATA = result[15:8]. On acceptance go to IDLE.
- TX_D_VLD and TX_P_DATA are registered outputs, stable while TX_busy = 1. TX_D_VLD drops in the cycle after the MSB is accepted.
- RX bytes arriving in ALU_START, ALU_WAIT, SEND_LSB or SEND_MSB are dropped, not buffered.
- ALU_A and ALU_B hold their values across frames; they change only in GET_A/GET_B or on reset.
- Command latency: last RX byte edge → ALU_EN high next cycle → ALU_Out_valid the cycle after → TX_D_VLD (LSB) the cycle after that, given TX_busy = 0.

Test Plan:
- Full frame: RX CC,0x12,0x34,0x2 (multiply), TX_busy = 0 → one ALU_EN pulse with A = 0x12, B = 0x34, FUN = 2; ALU_OUT = 0x03A8 → TX bytes 0xA8 then 0x03; Busy returns to 0.
- Reuse frame: after the previous test, RX DD,0x0 (add) → A/B still 0x12/0x34; TX bytes 0x46 then 0x00.
- TX backpressure: TX_busy = 1 for 5 cycles during SEND_LSB → TX_D_VLD and TX_P_DATA = 0xA8 held stable; MSB is offered only after the LSB is accepted.
- Garbage and drop: RX 0x55 in IDLE → stays IDLE, no ALU_EN. An RX byte during SEND_MSB → ignored; the next frame parses correctly.
- Timeout: ALU_Out_valid held 0 → Err pulses once exactly WAIT_MAX = 4 cycles after entering ALU_WAIT; no TX_D_VLD; state returns to IDLE.
- Reset mid-frame: Reset low after CC,0x12 → all outputs 0; the subsequent frame CC,0x01,0x01,0xA (equal) → TX bytes 0x01 then 0x00.

Source files
------------

// File: rtl/alu_cmd_ctrl_if.sv
// Link-side and ALU-side signal bundle for the ALU command front-end.
interface alu_cmd_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RES_WIDTH  = 16
);
    // UART receiver side
    logic [DATA_WIDTH-1:0] RX_P_DATA;
    logic                  RX_D_VLD;

    // ALU side
    logic [RES_WIDTH-1:0]  ALU_OUT;
    logic                  ALU_Out_valid;
    logic [DATA_WIDTH-1:0] ALU_A;
    logic [DATA_WIDTH-1:0] ALU_B;
    logic [3:0]            ALU_FUN;
    logic                  ALU_EN;

    // UART transmitter side
    logic                  TX_busy;
    logic [DATA_WIDTH-1:0] TX_P_DATA;
    logic                  TX_D_VLD;

    // Status
    logic                  Busy;
    logic                  Err;

    // Controller view
    modport master (
        input  RX_P_DATA, RX_D_VLD, ALU_OUT, ALU_Out_valid, TX_busy,
        output ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, Busy, Err
    );

    // Environment view (receiver, ALU, transmitter)
    modport slave (
        output RX_P_DATA, RX_D_VLD, ALU_OUT, ALU_Out_valid, TX_busy,
        input  ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, Busy, Err
    );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// Command front-end: parses RX frames, drives the ALU, returns the result LSB first.
module alu_cmd_ctrl #(
    parameter int unsigned          DATA_WIDTH   = 8,
    parameter int unsigned          RES_WIDTH    = 16,
    parameter logic [DATA_WIDTH-1:0] CMD_OP       = 8'hCC,
    parameter logic [DATA_WIDTH-1:0] CMD_OP_NOOPR = 8'hDD,
    parameter int unsigned          WAIT_MAX     = 4
) (
    input  logic           CLK,
    input  logic           Reset,
    alu_cmd_ctrl_if.master bus
);

    localparam int unsigned CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GET_A     = 3'd1,
        GET_B     = 3'd2,
        GET_FUN   = 3'd3,
        ALU_START = 3'd4,
        ALU_WAIT  = 3'd5,
        SEND_LSB  = 3'd6,
        SEND_MSB  = 3'd7
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [3:0]            fun_q, fun_d;
    logic [RES_WIDTH-1:0]  result_q, result_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  en_q, en_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_vld_q, tx_vld_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;

    // Next-state, datapath updates, and next values of the registered outputs
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        fun_d     = fun_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        tx_data_d = tx_data_q;

        case (state_q)
            IDLE: begin
                if (bus.RX_D_VLD) begin
                    if (bus.RX_P_DATA == CMD_OP) begin
                        state_d = GET_A;
                    end else if (bus.RX_P_DATA == CMD_OP_NOOPR) begin
                        state_d = GET_FUN;
                    end
                end
            end
            GET_A: begin
                if (bus.RX_D_VLD) begin
                    a_d     = bus.RX_P_DATA;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                if (bus.RX_D_VLD) begin
                    b_d     = bus.RX_P_DATA;
                    state_d = GET_FUN;
                end
            end
            GET_FUN: begin
                if (bus.RX_D_VLD) begin
                    fun_d   = bus.RX_P_DATA[3:0];
                    state_d = ALU_START;
                end
            end
            ALU_START: begin
                cnt_d   = '0;
                state_d = ALU_WAIT;
            end
            ALU_WAIT: begin
                if (bus.ALU_Out_valid) begin
                    result_d = bus.ALU_OUT;
                    state_d  = SEND_LSB;
                end else if (cnt_q == CNT_W'(WAIT_MAX - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SEND_LSB: begin
                if (!bus.TX_busy) begin
                    state_d = SEND_MSB;
                end
            end
            SEND_MSB: begin
                if (!bus.TX_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with the state itself
        en_d     = (state_d == ALU_START);
        busy_d   = (state_d != IDLE);
        tx_vld_d = (state_d == SEND_LSB) || (state_d == SEND_MSB);
        if (state_d == SEND_LSB) begin
            tx_data_d = result_d[DATA_WIDTH-1:0];
        end else if (state_d == SEND_MSB) begin
            tx_data_d = result_d[RES_WIDTH-1:DATA_WIDTH];
        end
    end

    // State and output registers
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            fun_q     <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            en_q      <= 1'b0;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            fun_q     <= fun_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            en_q      <= en_d;
            tx_data_q <= tx_data_d;
            tx_vld_q  <= tx_vld_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign bus.ALU_A     = a_q;
    assign bus.ALU_B     = b_q;
    assign bus.ALU_FUN   = fun_q;
    assign bus.ALU_EN    = en_q;
    assign bus.TX_P_DATA = tx_data_q;
    assign bus.TX_D_VLD  = tx_vld_q;
    assign bus.Busy      = busy_q;
    assign bus.Err       = err_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Scoreboard bench for alu_cmd_ctrl with a small registered ALU model.
module tb_alu_cmd_ctrl;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] f;
    } op_t;

    logic CLK   = 1'b0;
    logic Reset = 1'b0;
    always #5 CLK = ~CLK;

    alu_cmd_ctrl_if #(.DATA_WIDTH(8), .RES_WIDTH(16)) bus ();

    alu_cmd_ctrl #(
        .DATA_WIDTH  (8),
        .RES_WIDTH   (16),
        .CMD_OP      (8'hCC),
        .CMD_OP_NOOPR(8'hDD),
        .WAIT_MAX    (4)
    ) dut (
        .CLK  (CLK),
        .Reset(Reset),
        .bus  (bus)
    );

    int         total = 0;
    int         bad   = 0;
    op_t        exp_op[$];
    logic [7:0] exp_tx[$];
    int         exp_err = 0;
    logic       alu_on  = 1'b1;
    op_t        mon_op;
    logic [7:0] mon_tx;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Registered ALU model: result and valid appear the cycle after ALU_EN
    always @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            bus.ALU_OUT       <= 16'h0;
            bus.ALU_Out_valid <= 1'b0;
        end else begin
            bus.ALU_Out_valid <= bus.ALU_EN && alu_on;
            if (bus.ALU_EN) begin
                case (bus.ALU_FUN)
                    4'h0:    bus.ALU_OUT <= 16'(bus.ALU_A) + 16'(bus.ALU_B);
                    4'h2:    bus.ALU_OUT <= 16'(bus.ALU_A) * 16'(bus.ALU_B);
                    4'hA:    bus.ALU_OUT <= (bus.ALU_A == bus.ALU_B) ? 16'h1 : 16'h0;
                    default: bus.ALU_OUT <= 16'h0;
                endcase
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an ALU command, TX byte or error
    always @(negedge CLK) begin
        if (Reset) begin
            if (bus.ALU_EN) begin
                if (exp_op.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL alu_en: unexpected pulse A=%h B=%h FUN=%h", bus.ALU_A, bus.ALU_B, bus.ALU_FUN);
                end else begin
                    mon_op = exp_op.pop_front();
                    chk("alu_a", 16'(bus.ALU_A), 16'(mon_op.a));
                    chk("alu_b", 16'(bus.ALU_B), 16'(mon_op.b));
                    chk("alu_fun", 16'(bus.ALU_FUN), 16'(mon_op.f));
                end
            end
            if (bus.TX_D_VLD && !bus.TX_busy) begin
                if (exp_tx.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_byte: unexpected byte %h", bus.TX_P_DATA);
                end else begin
                    mon_tx = exp_tx.pop_front();
                    chk("tx_byte", 16'(bus.TX_P_DATA), 16'(mon_tx));
                end
            end
            if (bus.Err) begin
                total++;
                if (exp_err == 0) begin
                    bad++;
                    $display("FAIL err: unexpected pulse at %0t", $time);
                end else begin
                    exp_err--;
                end
            end
        end
    end

    // Inputs are driven 1 time unit after a rising edge; caller is already aligned there
    task automatic send_byte(input logic [7:0] b);
        bus.RX_P_DATA = b;
        bus.RX_D_VLD  = 1'b1;
        @(posedge CLK);
        #1;
        bus.RX_D_VLD  = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (bus.Busy && n < budget) begin
            step(1);
            n++;
        end
        chk(name, 16'(bus.Busy), 16'h0);
    endtask

    task automatic push_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        op_t o;
        o.a = a;
        o.b = b;
        o.f = f;
        exp_op.push_back(o);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.RX_P_DATA = 8'h00;
        bus.RX_D_VLD  = 1'b0;
        bus.TX_busy   = 1'b0;
        Reset         = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        // Reset values
        chk("rst_alu_a", 16'(bus.ALU_A), 16'h0);
        chk("rst_alu_fun", 16'(bus.ALU_FUN), 16'h0);
        chk("rst_alu_en", 16'(bus.ALU_EN), 16'h0);
        chk("rst_tx_vld", 16'(bus.TX_D_VLD), 16'h0);
        chk("rst_tx_data", 16'(bus.TX_P_DATA), 16'h0);
        chk("rst_busy", 16'(bus.Busy), 16'h0);
        chk("rst_err", 16'(bus.Err), 16'h0);
        Reset = 1'b1;
        step(1);

        // Full frame: 0x12 * 0x34 = 0x03A8
        push_op(8'h12, 8'h34, 4'h2);
        exp_tx.push_back(8'hA8);
        exp_tx.push_back(8'h03);
        send_byte(8'hCC);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h02);
        chk("latency_alu_en", 16'(bus.ALU_EN), 16'h1);
        step(1);
        chk("latency_alu_en_drop", 16'(bus.ALU_EN), 16'h0);
        step(1);
        chk("latency_tx_vld", 16'(bus.TX_D_VLD), 16'h1);
        wait_idle("full_busy_done", 20);
        chk("full_tx_vld_drop", 16'(bus.TX_D_VLD), 16'h0);

        // Reuse frame: stored operands, add -> 0x0046
        push_op(8'h12, 8'h34, 4'h0);
        exp_tx.push_back(8'h46);
        exp_tx.push_back(8'h00);
        send_byte(8'hDD);
        send_byte(8'h00);
        wait_idle("reuse_busy_done", 20);

        // Backpressure on LSB, then a byte dropped during SEND_MSB
        bus.TX_busy = 1'b1;
        push_op(8'h12, 8'h34, 4'h2);
        exp_tx.push_back(8'hA8);
        exp_tx.push_back(8'h03);
        send_byte(8'hCC);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h02);
        n = 0;
        while (!bus.TX_D_VLD && n < 10) begin
            step(1);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_tx_vld_hold", 16'(bus.TX_D_VLD), 16'h1);
            chk("bp_tx_data_hold", 16'(bus.TX_P_DATA), 16'h00A8);
            step(1);
        end
        bus.TX_busy = 1'b0;
        step(1);
        bus.TX_busy = 1'b1;
        chk("bp_msb_data", 16'(bus.TX_P_DATA), 16'h0003);
        chk("bp_msb_vld", 16'(bus.TX_D_VLD), 16'h1);
        send_byte(8'hCC);
        chk("drop_msb_data", 16'(bus.TX_P_DATA), 16'h0003);
        bus.TX_busy = 1'b0;
        wait_idle("bp_busy_done", 20);
        step(2);
        chk("drop_stays_idle", 16'(bus.Busy), 16'h0);

        // Garbage byte in IDLE, then a clean frame: 5 + 7 = 0x000C
        send_byte(8'h55);
        step(3);
        chk("garbage_idle", 16'(bus.Busy), 16'h0);
        push_op(8'h05, 8'h07, 4'h0);
        exp_tx.push_back(8'h0C);
        exp_tx.push_back(8'h00);
        send_byte(8'hCC);
        send_byte(8'h05);
        send_byte(8'h07);
        send_byte(8'h00);
        wait_idle("garbage_next_done", 20);

        // Timeout: ALU never answers
        alu_on = 1'b0;
        push_op(8'h05, 8'h07, 4'h2);
        exp_err = exp_err + 1;
        send_byte(8'hDD);
        send_byte(8'h02);
        chk("to_alu_en", 16'(bus.ALU_EN), 16'h1);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!bus.Err && n < 10);
        chk("to_err_latency", 16'(n), 16'd5);
        chk("to_busy", 16'(bus.Busy), 16'h0);
        step(1);
        chk("to_err_single", 16'(bus.Err), 16'h0);
        chk("to_no_tx", 16'(bus.TX_D_VLD), 16'h0);
        alu_on = 1'b1;

        // Reset mid-frame, then an equality frame -> 0x0001
        send_byte(8'hCC);
        send_byte(8'h12);
        Reset = 1'b0;
        #1;
        chk("mid_rst_alu_a", 16'(bus.ALU_A), 16'h0);
        chk("mid_rst_alu_b", 16'(bus.ALU_B), 16'h0);
        chk("mid_rst_fun", 16'(bus.ALU_FUN), 16'h0);
        chk("mid_rst_busy", 16'(bus.Busy), 16'h0);
        step(1);
        Reset = 1'b1;
        step(1);
        push_op(8'h01, 8'h01, 4'hA);
        exp_tx.push_back(8'h01);
        exp_tx.push_back(8'h00);
        send_byte(8'hCC);
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h0A);
        wait_idle("eq_busy_done", 20);
        step(3);

        // Scoreboard must be drained
        chk("sb_op_left", 16'(exp_op.size()), 16'h0);
        chk("sb_tx_left", 16'(exp_tx.size()), 16'h0);
        chk("sb_err_left", 16'(exp_err), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
